// File: rtl/mac_pe.sv
// Signed multiply-accumulate PE for a weight-stationary systolic array.
// It forwards its operands downstream, registers their product, then adds the upstream partial sum.
module mac_pe #(
  parameter int unsigned IFMAP_BITWIDTH = 16,
  parameter int unsigned W_BITWIDTH     = 8,
  parameter int unsigned OFMAP_BITWIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic signed [W_BITWIDTH-1:0]      w_data_in,
  input  logic signed [IFMAP_BITWIDTH-1:0]  ifmap_data_in,
  input  logic signed [OFMAP_BITWIDTH-1:0]  MAC_data_in,
  output logic signed [W_BITWIDTH-1:0]      w_data_out,
  output logic signed [IFMAP_BITWIDTH-1:0]  ifmap_data_out,
  output logic signed [OFMAP_BITWIDTH-1:0]  MAC_data_out
);

  localparam int unsigned PROD_BITWIDTH = W_BITWIDTH + IFMAP_BITWIDTH;

  logic signed [W_BITWIDTH-1:0]     w_q,     w_d;
  logic signed [IFMAP_BITWIDTH-1:0] ifmap_q, ifmap_d;
  logic signed [PROD_BITWIDTH-1:0]  prod_q,  prod_d;
  logic signed [OFMAP_BITWIDTH-1:0] mac_q,   mac_d;

  logic signed [PROD_BITWIDTH-1:0]  w_ext;
  logic signed [PROD_BITWIDTH-1:0]  ifmap_ext;

  always_comb begin
    w_d       = w_data_in;
    ifmap_d   = ifmap_data_in;
    // Sign-extend both operands to the full product width so the product is exact.
    w_ext     = PROD_BITWIDTH'(w_data_in);
    ifmap_ext = PROD_BITWIDTH'(ifmap_data_in);
    prod_d    = w_ext * ifmap_ext;
    mac_d     = OFMAP_BITWIDTH'(prod_q) + MAC_data_in;
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      w_q     <= '0;
      ifmap_q <= '0;
      prod_q  <= '0;
      mac_q   <= '0;
    end else begin
      w_q     <= w_d;
      ifmap_q <= ifmap_d;
      prod_q  <= prod_d;
      mac_q   <= mac_d;
    end
  end

  assign w_data_out     = w_q;
  assign ifmap_data_out = ifmap_q;
  assign MAC_data_out   = mac_q;

endmodule

// File: tb/tb_mac_pe.sv
// Directed self-checking bench for mac_pe: a vector table for the streaming chain,
// plus hand-written sequences for extreme operands, wrap-around and mid-stream reset.
module tb_mac_pe;

  logic               clk  = 1'b0;
  logic               rstn = 1'b0;
  logic signed [7:0]  w_data_in      = '0;
  logic signed [15:0] ifmap_data_in  = '0;
  logic signed [31:0] MAC_data_in    = '0;
  logic signed [7:0]  w_data_out;
  logic signed [15:0] ifmap_data_out;
  logic signed [31:0] MAC_data_out;

  int total = 0;
  int bad   = 0;

  mac_pe #(
    .IFMAP_BITWIDTH(16),
    .W_BITWIDTH    (8),
    .OFMAP_BITWIDTH(32)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .w_data_in     (w_data_in),
    .ifmap_data_in (ifmap_data_in),
    .MAC_data_in   (MAC_data_in),
    .w_data_out    (w_data_out),
    .ifmap_data_out(ifmap_data_out),
    .MAC_data_out  (MAC_data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0]  w;
    logic signed [15:0] ifm;
    int                 mac;
    logic signed [7:0]  ew;
    logic signed [15:0] eif;
    int                 emac;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive_step(input logic signed [7:0] w, input logic signed [15:0] ifm,
                            input int mac);
    w_data_in     = w;
    ifmap_data_in = ifm;
    MAC_data_in   = mac;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_w"},   int'(w_data_out),     0);
    chk({name, "_if"},  int'(ifmap_data_out), 0);
    chk({name, "_mac"}, int'(MAC_data_out),   0);
  endtask

  initial begin
    vecs[0] = '{w: -8'sd128, ifm: 16'sd1,  mac: 0,    ew: -8'sd128, eif: 16'sd1,  emac: 0};
    vecs[1] = '{w: -8'sd105, ifm: -16'sd2, mac: 0,    ew: -8'sd105, eif: -16'sd2, emac: -128};
    vecs[2] = '{w: -8'sd82,  ifm: 16'sd4,  mac: -128, ew: -8'sd82,  eif: 16'sd4,  emac: 82};
    for (int k = 3; k < NVEC; k++) begin
      vecs[k].w    = vecs[k-1].w + 8'sd23;
      vecs[k].ifm  = 16'(-32'sd2 * int'(vecs[k-1].ifm));
      vecs[k].mac  = vecs[k-1].emac;
      vecs[k].ew   = vecs[k].w;
      vecs[k].eif  = vecs[k].ifm;
      vecs[k].emac = int'(vecs[k-1].w) * int'(vecs[k-1].ifm) + vecs[k].mac;
    end

    // Reset held across several edges with non-zero inputs.
    #1 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_step(8'sd77, -16'sd1234, 32'sd99999);
      chk_zero("reset_hold");
    end
    rstn = 1'b0;

    // Streaming chain: each row's MAC input is the previous row's expected output.
    for (int k = 0; k < NVEC; k++) begin
      drive_step(vecs[k].w, vecs[k].ifm, vecs[k].mac);
      chk($sformatf("stream%0d_w", k),   int'(w_data_out),     int'(vecs[k].ew));
      chk($sformatf("stream%0d_if", k),  int'(ifmap_data_out), int'(vecs[k].eif));
      chk($sformatf("stream%0d_mac", k), int'(MAC_data_out),   vecs[k].emac);
    end

    // Most negative weight times most negative feature value.
    drive_step(-8'sd128, -16'sd32768, 0);
    chk("extreme_w",  int'(w_data_out),     -128);
    chk("extreme_if", int'(ifmap_data_out), -32768);
    drive_step(8'sd0, 16'sd0, 0);
    chk("extreme_mac", int'(MAC_data_out), 4194304);

    // Sum wraps past the positive limit with no saturation.
    drive_step(8'sd1, 16'sd1, 0);
    drive_step(8'sd0, 16'sd0, 32'h7FFF_FFFF);
    chk("wrap_mac", int'(MAC_data_out), int'(32'h8000_0000));
    chk("wrap_neg", int'(MAC_data_out < 0), 1);

    // Mid-stream reset asserted between edges clears outputs immediately.
    drive_step(8'sd9, 16'sd11, 500);
    drive_step(8'sd3, -16'sd4, 600);
    chk("pre_rst_mac", int'(MAC_data_out), 99 + 600);
    #3 rstn = 1'b1;
    #1;
    chk_zero("async_rst");
    drive_step(8'sd42, 16'sd42, 4242);
    chk_zero("async_rst_edge");
    #2 rstn = 1'b0;
    drive_step(8'sd5, 16'sd7, 1234);
    chk("post_rst_w",   int'(w_data_out),     5);
    chk("post_rst_if",  int'(ifmap_data_out), 7);
    chk("post_rst_mac", int'(MAC_data_out),   1234);
    drive_step(8'sd0, 16'sd0, 10);
    chk("post_rst_mac2", int'(MAC_data_out), 45);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
